// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned INSTR_BYTES  = 4;

   typedef enum logic [1:0] {FREE, PENDING, READY} entry_state_t;
   typedef enum logic [1:0] {FETCH, BLOCKED, FLUSH} fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of PC, instruction-memory and decode handshakes around the fetch stage.
interface instruction_fetch_if
   import fetch_pkg::*;
   #(parameter int unsigned XLEN = XLEN_DEFAULT);

   logic [XLEN-1:0] pc_address;
   logic            pc_advance;
   logic            redirect;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst_data;
   logic [XLEN-1:0] inst_pc;
   logic [XLEN-1:0] inst_next_pc;

   modport master (
      input  pc_address, redirect, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
      output pc_advance, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_next_pc
   );

   modport slave (
      output pc_address, redirect, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
      input  pc_advance, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_next_pc
   );

endinterface

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at tail, filled oldest-pending first
// and popped from head; clear empties everything and rewinds the pointers.
module fetch_queue
   import fetch_pkg::*;
   #(
      parameter  int unsigned XLEN  = XLEN_DEFAULT,
      parameter  int unsigned DEPTH = 2,
      localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
      localparam int unsigned CW    = $clog2(DEPTH + 1)
   )
   (
      input  logic            clk,
      input  logic            reset,
      input  logic            clear,
      input  logic            alloc,
      input  logic [XLEN-1:0] alloc_pc,
      input  logic            fill,
      input  logic [XLEN-1:0] fill_data,
      input  logic            pop,
      output logic            head_ready,
      output logic [XLEN-1:0] head_pc,
      output logic [XLEN-1:0] head_data,
      output logic [CW-1:0]   occ_cnt,
      output logic [CW-1:0]   pend_cnt
   );

   entry_state_t    st      [DEPTH];
   logic [XLEN-1:0] pc_q    [DEPTH];
   logic [XLEN-1:0] data_q  [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [PW-1:0]   fptr;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Fill and pop never target the same entry (PENDING vs READY), and a
   // full queue never allocates, so the three updates are independent.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int unsigned i = 0; i < DEPTH; i++) st[i] <= FREE;
         head     <= '0;
         tail     <= '0;
         fptr     <= '0;
         occ_cnt  <= '0;
         pend_cnt <= '0;
      end else begin
         if (pop) begin
            st[head] <= FREE;
            head     <= wrap_inc(head);
         end
         if (fill) begin
            st[fptr] <= READY;
            fptr     <= wrap_inc(fptr);
         end
         if (alloc) begin
            st[tail] <= PENDING;
            tail     <= wrap_inc(tail);
         end
         occ_cnt  <= occ_cnt + CW'(alloc) - CW'(pop);
         pend_cnt <= pend_cnt + CW'(alloc) - CW'(fill);
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) pc_q[tail]   <= alloc_pc;
      if (fill)  data_q[fptr] <= fill_data;
   end

   always_comb begin
      head_ready = (st[head] == READY);
      head_pc    = pc_q[head];
      head_data  = data_q[head];
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: credit-limited in-order requests, redirect flush with response dropping.
// Define FETCH_TRACE_EN to print decode handshakes and redirects in simulation.
module instruction_fetch
   import fetch_pkg::*;
   #(
      parameter int unsigned XLEN  = XLEN_DEFAULT,
      parameter int unsigned DEPTH = 2
   )
   (
      input logic clk,
      input logic reset,
      instruction_fetch_if.master bus
   );

   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_state_t    state;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   drop_nxt;
   logic [CW-1:0]   occ_cnt;
   logic [CW-1:0]   occ_nxt;
   logic [CW-1:0]   pend_cnt;
   logic [CW:0]     credit;
   logic [CW:0]     credit_nxt;
   logic            req_fire;
   logic            resp_fill;
   logic            resp_drop;
   logic            resp_consumed;
   logic            pop;
   logic            head_ready;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_data;

   always_comb begin
      credit             = (CW+1)'(DEPTH) - {1'b0, occ_cnt} - {1'b0, drop_cnt};
      bus.imem_req_valid = (state == FETCH) && (credit != '0) && !bus.redirect && !reset;
      bus.imem_req_addr  = bus.pc_address;
      req_fire           = bus.imem_req_valid && bus.imem_req_ready;
      bus.pc_advance     = req_fire;
      resp_drop          = bus.imem_resp_valid && (drop_cnt != '0);
      resp_fill          = bus.imem_resp_valid && (drop_cnt == '0) && (pend_cnt != '0)
                           && !bus.redirect && !reset;
      resp_consumed      = bus.imem_resp_valid && ((drop_cnt != '0) || (pend_cnt != '0));
      bus.inst_valid     = head_ready && !bus.redirect;
      pop                = bus.inst_valid && bus.inst_ready;
      bus.inst_data      = head_ready ? head_data : '0;
      bus.inst_pc        = head_ready ? head_pc : '0;
      bus.inst_next_pc   = head_ready ? head_pc + XLEN'(INSTR_BYTES) : '0;
   end

   // Outstanding drops carry over a redirect; a response arriving in the
   // redirect cycle retires one of them (or the oldest pending fetch).
   always_comb begin
      if (bus.redirect) begin
         occ_nxt  = '0;
         drop_nxt = drop_cnt + pend_cnt - CW'(resp_consumed);
      end else begin
         occ_nxt  = occ_cnt + CW'(req_fire) - CW'(pop);
         drop_nxt = drop_cnt - CW'(resp_drop);
      end
      credit_nxt = (CW+1)'(DEPTH) - {1'b0, occ_nxt} - {1'b0, drop_nxt};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_nxt;
         if (bus.redirect) begin
            state <= (drop_nxt != '0) ? FLUSH : FETCH;
         end else begin
            case (state)
               FLUSH: begin
                  if (drop_nxt == '0) state <= (credit_nxt == '0) ? BLOCKED : FETCH;
               end
               default: state <= (credit_nxt == '0) ? BLOCKED : FETCH;
            endcase
         end
      end
   end

   fetch_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .clear      (bus.redirect),
      .alloc      (req_fire),
      .alloc_pc   (bus.pc_address),
      .fill       (resp_fill),
      .fill_data  (bus.imem_resp_data),
      .pop        (pop),
      .head_ready (head_ready),
      .head_pc    (head_pc),
      .head_data  (head_data),
      .occ_cnt    (occ_cnt),
      .pend_cnt   (pend_cnt)
   );

`ifdef FETCH_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && bus.inst_valid && bus.inst_ready)
         $display("FETCH: pc=0x%h inst=0x%h", bus.inst_pc, bus.inst_data);
      if (!reset && bus.redirect)
         $display("FLUSH: dropped=%0d", drop_nxt);
   end
`else
   // untraced build: no simulation output
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: bench-side PC and fixed-latency memory model.
module tb_instruction_fetch;
   import fetch_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;

   logic clk = 1'b0;
   logic reset;

   instruction_fetch_if #(.XLEN(XLEN)) bus ();

   instruction_fetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;
   int unsigned lat    = 1;
   int unsigned pops   = 0;
   logic [31:0] pc_init     = '0;
   logic [31:0] jump_target = '0;
   req_t pipe[$];
   exp_t exp_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // PC register and instruction memory; expected words are queued at request time
   initial begin
      logic [31:0] pc_nxt;
      bus.pc_address      = '0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         pc_nxt = bus.pc_address;
         if (reset) begin
            pipe.delete();
            exp_q.delete();
            pc_nxt = pc_init;
         end else if (bus.redirect) begin
            exp_q.delete();
            pc_nxt = jump_target;
         end else begin
            if (bus.imem_req_valid) chk("req_addr_tracks_pc", bus.imem_req_addr, bus.pc_address);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               pipe.push_back('{addr: bus.pc_address, due: cyc + lat});
               exp_q.push_back('{pc: bus.pc_address, data: mem_word(bus.pc_address)});
            end
            if (bus.pc_advance) pc_nxt = bus.pc_address + 32'd4;
         end
         @(posedge clk);
         #1;
         cyc++;
         bus.pc_address = pc_nxt;
         if (pipe.size() != 0 && pipe[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(pipe[0].addr);
            void'(pipe.pop_front());
         end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
         end
      end
   end

   // Decode-side monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus.inst_valid && bus.inst_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_inst: got pc 0x%08h, none expected", bus.inst_pc);
            end else begin
               e = exp_q.pop_front();
               chk("sb_inst_pc", bus.inst_pc, e.pc);
               chk("sb_inst_data", bus.inst_data, e.data);
               chk("sb_inst_next_pc", bus.inst_next_pc, e.pc + 32'd4);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      int k;
      int n;
      bit found;

      reset              = 1'b1;
      bus.redirect       = 1'b0;
      bus.inst_ready     = 1'b1;
      bus.imem_req_ready = 1'b1;

      // reset values
      go(); go(); mid();
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_pc_advance", bus.pc_advance, 0);
      chk("rst_inst_valid", bus.inst_valid, 0);
      chk("rst_inst_data", bus.inst_data, 0);
      chk("rst_inst_pc", bus.inst_pc, 0);
      chk("rst_inst_next_pc", bus.inst_next_pc, 0);
      chk("rst_req_addr", bus.imem_req_addr, 0);

      // streaming from 0x0, latency 1
      go(); reset = 1'b0; mid();
      chk("t1_req_valid", bus.imem_req_valid, 1);
      chk("t1_pc_advance0", bus.pc_advance, 1);
      chk("t1_req_addr0", bus.imem_req_addr, 32'h0);
      go(); mid();
      chk("t1_pc_advance1", bus.pc_advance, 1);
      chk("t1_req_addr1", bus.imem_req_addr, 32'h4);
      chk("t1_valid_lat1", bus.inst_valid, 0);
      go(); mid();
      chk("t1_valid_lat2", bus.inst_valid, 1);
      chk("t1_pc0", bus.inst_pc, 32'h0);
      chk("t1_next0", bus.inst_next_pc, 32'h4);
      chk("t1_data0", bus.inst_data, 32'h0000_FFFF);
      go(); mid();
      chk("t1_pc1", bus.inst_pc, 32'h4);
      chk("t1_next1", bus.inst_next_pc, 32'h8);
      repeat (4) begin go(); mid(); end
      chk("t1_decoded_3", pops >= 3, 1);

      // decode stalled: queue fills and fetch stops
      go(); bus.inst_ready = 1'b0; mid();
      repeat (5) begin go(); mid(); end
      chk("t2_req_valid_full", bus.imem_req_valid, 0);
      chk("t2_pc_advance_full", bus.pc_advance, 0);
      chk("t2_inst_valid_full", bus.inst_valid, 1);
      go(); bus.inst_ready = 1'b1; mid();
      chk("t2_single_pop", bus.inst_valid, 1);
      go(); bus.inst_ready = 1'b0; mid();
      n = int'(bus.pc_advance);
      repeat (4) begin go(); mid(); n += int'(bus.pc_advance); end
      chk("t2_one_request", n, 1);
      go(); bus.inst_ready = 1'b1; mid();
      repeat (6) begin go(); mid(); end

      // latency 3, redirect with two fetches pending
      go(); bus.imem_req_ready = 1'b0; mid();
      repeat (6) begin go(); mid(); end
      chk("t3_drained", bus.inst_valid, 0);
      jump_target = 32'h100;
      go(); bus.imem_req_ready = 1'b1; lat = 3; mid();
      chk("t3_req0", bus.pc_advance, 1);
      go(); mid();
      chk("t3_req1", bus.pc_advance, 1);
      go(); bus.redirect = 1'b1; mid();
      chk("t3_redir_req_valid", bus.imem_req_valid, 0);
      chk("t3_redir_inst_valid", bus.inst_valid, 0);
      for (int i = 0; i < 2; i++) begin
         go(); bus.redirect = 1'b0; mid();
         chk("t3_drop_resp", bus.imem_resp_valid, 1);
         chk("t3_drop_no_req", bus.imem_req_valid, 0);
         chk("t3_drop_no_inst", bus.inst_valid, 0);
      end
      go(); mid();
      chk("t3_target_req", bus.imem_req_valid, 1);
      chk("t3_target_addr", bus.imem_req_addr, 32'h100);
      k = 0;
      do begin go(); mid(); k++; end while (!bus.inst_valid && k < 12);
      chk("t3_target_latency", k, 4);
      chk("t3_target_pc", bus.inst_pc, 32'h100);
      chk("t3_target_next", bus.inst_next_pc, 32'h104);
      chk("t3_target_data", bus.inst_data, 32'h0100_FFFF);

      // redirect coinciding with a response and a decode handshake
      go(); lat = 1; jump_target = 32'h200; mid();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         go(); #1;
         if (bus.inst_valid && bus.imem_resp_valid) begin
            bus.redirect = 1'b1;
            found = 1'b1;
         end
         mid();
      end
      chk("t4_found", found, 1);
      chk("t4_no_handshake", bus.inst_valid, 0);
      go(); bus.redirect = 1'b0; mid();
      chk("t4_empty", bus.inst_valid, 0);
      chk("t4_req_valid", bus.imem_req_valid, 1);
      chk("t4_req_addr", bus.imem_req_addr, 32'h200);
      k = 0;
      do begin go(); mid(); k++; end while (!bus.inst_valid && k < 12);
      chk("t4_target_pc", bus.inst_pc, 32'h200);
      chk("t4_target_data", bus.inst_data, 32'h0200_FFFF);

      // PC wrap, then reset with READY entries
      go(); reset = 1'b1; pc_init = 32'hFFFF_FFFC; mid();
      go(); mid();
      go(); reset = 1'b0; mid();
      chk("t5_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
      k = 0;
      do begin go(); mid(); k++; end while (!bus.inst_valid && k < 12);
      chk("t5_wrap_pc", bus.inst_pc, 32'hFFFF_FFFC);
      chk("t5_wrap_next", bus.inst_next_pc, 32'h0000_0000);
      chk("t5_wrap_data", bus.inst_data, 32'hFFFC_0000);
      go(); bus.inst_ready = 1'b0; mid();
      repeat (4) begin go(); mid(); end
      chk("t5_ready_before_reset", bus.inst_valid, 1);
      go(); reset = 1'b1; pc_init = 32'h40; mid();
      go(); mid();
      chk("t5_reset_inst_valid", bus.inst_valid, 0);
      chk("t5_reset_inst_pc", bus.inst_pc, 0);
      chk("t5_reset_req_valid", bus.imem_req_valid, 0);

      // memory backpressure: request held stable
      go(); reset = 1'b0; bus.imem_req_ready = 1'b0; bus.inst_ready = 1'b1; mid();
      for (int i = 0; i < 5; i++) begin
         if (i != 0) begin go(); mid(); end
         chk("t6_hold_valid", bus.imem_req_valid, 1);
         chk("t6_hold_addr", bus.imem_req_addr, 32'h40);
         chk("t6_hold_no_advance", bus.pc_advance, 0);
      end
      go(); bus.imem_req_ready = 1'b1; mid();
      chk("t6_accept", bus.pc_advance, 1);
      chk("t6_accept_addr", bus.imem_req_addr, 32'h40);
      repeat (6) begin go(); mid(); end

      // drain remaining expected instructions
      go(); bus.imem_req_ready = 1'b0; mid();
      k = 0;
      while (exp_q.size() != 0 && k < 30) begin go(); mid(); k++; end
      chk("drain_outstanding", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
